// File: rtl/hazard_stall_unit.sv
// Pipeline interlock for the 5-stage core: load-use stall, data-memory wait freeze,
// taken-branch flush, and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic [REG_ADDR_W-1:0] i_Rs1AddrDecode,
  input  logic [REG_ADDR_W-1:0] i_Rs2AddrDecode,
  input  logic                  i_Rs1UsedDecode,
  input  logic                  i_Rs2UsedDecode,
  input  logic                  i_RfWeExec,
  input  logic [REG_ADDR_W-1:0] i_RfDstExec,
  input  logic [1:0]            i_RfDataInSelExec,
  input  logic                  i_RfWeMem,
  input  logic [REG_ADDR_W-1:0] i_RfDstMem,
  input  logic [1:0]            i_RfDataInSelMem,
  input  logic                  i_MemAccessMem,
  input  logic                  i_MemReady,
  input  logic                  i_BranchTakenExec,
  input  logic                  i_CntClr,
  output logic                  o_PcWe,
  output logic                  o_IfIdWe,
  output logic                  o_IfIdFlush,
  output logic                  o_IdExFlush,
  output logic                  o_ExMemWe,
  output logic                  o_MemWbBubble,
  output logic                  o_MemTimeout,
  output logic [CNT_W-1:0]      o_StallCycles
);

  localparam int WAIT_BITS = $clog2(MEM_TIMEOUT + 1);
  localparam int WAIT_W    = (WAIT_BITS < 4) ? 4 : WAIT_BITS;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0] SEL_LOAD = 2'b01;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t            state;
  logic [WAIT_W-1:0] waitCnt;

  logic loadExec, loadMem;
  logic hitExec, hitMem;
  logic loadHazard;
  logic memBusy;

  // Only loads are interlocked; every other producer is covered by forwarding.
  assign loadExec = i_RfWeExec && (i_RfDataInSelExec == SEL_LOAD);
  assign loadMem  = i_RfWeMem  && (i_RfDataInSelMem  == SEL_LOAD);

  assign hitExec = (i_Rs1UsedDecode && (i_Rs1AddrDecode == i_RfDstExec)) ||
                   (i_Rs2UsedDecode && (i_Rs2AddrDecode == i_RfDstExec));
  assign hitMem  = (i_Rs1UsedDecode && (i_Rs1AddrDecode == i_RfDstMem)) ||
                   (i_Rs2UsedDecode && (i_Rs2AddrDecode == i_RfDstMem));

  assign loadHazard = (loadExec && hitExec) || (loadMem && hitMem);
  assign memBusy    = i_MemAccessMem && !i_MemReady;

  always_comb begin
    o_PcWe        = 1'b1;
    o_IfIdWe      = 1'b1;
    o_ExMemWe     = 1'b1;
    o_IfIdFlush   = 1'b0;
    o_IdExFlush   = 1'b0;
    o_MemWbBubble = 1'b0;
    if (!i_Rst_n || state == ERR) begin
      o_PcWe        = 1'b0;
      o_IfIdWe      = 1'b0;
      o_ExMemWe     = 1'b0;
      o_IfIdFlush   = 1'b1;
      o_IdExFlush   = 1'b1;
      o_MemWbBubble = 1'b1;
    end else if ((state == RUN && memBusy) || (state == MEM_WAIT && !i_MemReady)) begin
      o_PcWe        = 1'b0;
      o_IfIdWe      = 1'b0;
      o_ExMemWe     = 1'b0;
      o_MemWbBubble = 1'b1;
    end else if (i_BranchTakenExec) begin
      // A stalled ID instruction behind a taken branch is wrong-path: flush, don't stall.
      o_IfIdFlush = 1'b1;
      o_IdExFlush = 1'b1;
    end else if (loadHazard) begin
      o_PcWe      = 1'b0;
      o_IfIdWe    = 1'b0;
      o_IdExFlush = 1'b1;
    end
  end

  assign o_MemTimeout = (state == ERR);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memBusy) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (i_MemReady) begin
            state <= RUN;
          end else begin
            waitCnt <= waitCnt + 1'b1;
            // The RUN cycle that detected busy counts as the first tolerated cycle.
            if (waitCnt >= WAIT_LAST) state <= ERR;
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      o_StallCycles <= '0;
    else if (i_CntClr)
      o_StallCycles <= '0;
    else if (!o_PcWe && o_StallCycles != {CNT_W{1'b1}})
      o_StallCycles <= o_StallCycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: default instance plus a small instance (MEM_TIMEOUT=3, CNT_W=4) on shared inputs.
module tb_hazard_stall_unit;
  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] rs1Addr, rs2Addr, dstExec, dstMem;
  logic       rs1Used, rs2Used, weExec, weMem, memAcc, memRdy, brTaken, cntClr;
  logic [1:0] selExec, selMem;

  logic pcWe, ifIdWe, ifIdFlush, idExFlush, exMemWe, memWbBubble, memTimeout;
  logic [15:0] stallCycles;
  logic pcWe2, ifIdWe2, ifIdFlush2, idExFlush2, exMemWe2, memWbBubble2, memTimeout2;
  logic [3:0] stallCycles2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .i_Clk(clk), .i_Rst_n(rstN),
    .i_Rs1AddrDecode(rs1Addr), .i_Rs2AddrDecode(rs2Addr),
    .i_Rs1UsedDecode(rs1Used), .i_Rs2UsedDecode(rs2Used),
    .i_RfWeExec(weExec), .i_RfDstExec(dstExec), .i_RfDataInSelExec(selExec),
    .i_RfWeMem(weMem), .i_RfDstMem(dstMem), .i_RfDataInSelMem(selMem),
    .i_MemAccessMem(memAcc), .i_MemReady(memRdy), .i_BranchTakenExec(brTaken),
    .i_CntClr(cntClr),
    .o_PcWe(pcWe), .o_IfIdWe(ifIdWe), .o_IfIdFlush(ifIdFlush), .o_IdExFlush(idExFlush),
    .o_ExMemWe(exMemWe), .o_MemWbBubble(memWbBubble), .o_MemTimeout(memTimeout),
    .o_StallCycles(stallCycles)
  );

  hazard_stall_unit #(.REG_ADDR_W(5), .CNT_W(4), .MEM_TIMEOUT(3)) dut2 (
    .i_Clk(clk), .i_Rst_n(rstN),
    .i_Rs1AddrDecode(rs1Addr), .i_Rs2AddrDecode(rs2Addr),
    .i_Rs1UsedDecode(rs1Used), .i_Rs2UsedDecode(rs2Used),
    .i_RfWeExec(weExec), .i_RfDstExec(dstExec), .i_RfDataInSelExec(selExec),
    .i_RfWeMem(weMem), .i_RfDstMem(dstMem), .i_RfDataInSelMem(selMem),
    .i_MemAccessMem(memAcc), .i_MemReady(memRdy), .i_BranchTakenExec(brTaken),
    .i_CntClr(cntClr),
    .o_PcWe(pcWe2), .o_IfIdWe(ifIdWe2), .o_IfIdFlush(ifIdFlush2), .o_IdExFlush(idExFlush2),
    .o_ExMemWe(exMemWe2), .o_MemWbBubble(memWbBubble2), .o_MemTimeout(memTimeout2),
    .o_StallCycles(stallCycles2)
  );

  task automatic clearIns();
    rs1Addr = '0; rs2Addr = '0; dstExec = '0; dstMem = '0;
    rs1Used = 0; rs2Used = 0; weExec = 0; weMem = 0; selExec = '0; selMem = '0;
    memAcc = 0; memRdy = 0; brTaken = 0; cntClr = 0;
  endtask

  // Leaves time 1 ns after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    clearIns();
    rstN = 0; #2; rstN = 1; #1;
  endtask

  task automatic test_reset();
    clearIns(); rstN = 0; #1;
    checks++; if (pcWe !== 1'b0) begin failures++; $display("FAIL rst_pcWe got=%b exp=0", pcWe); end
    checks++; if ({ifIdFlush, idExFlush, memWbBubble} !== 3'b111) begin failures++; $display("FAIL rst_flush got=%b exp=111", {ifIdFlush, idExFlush, memWbBubble}); end
    checks++; if (stallCycles !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", stallCycles); end
    #2; rstN = 1; #1;
    checks++; if ({pcWe, ifIdWe, exMemWe, ifIdFlush, idExFlush, memWbBubble} !== 6'b111000) begin failures++; $display("FAIL rst_release got=%b exp=111000", {pcWe, ifIdWe, exMemWe, ifIdFlush, idExFlush, memWbBubble}); end
    // enter MEM_WAIT and assert reset mid-wait
    memAcc = 1; memRdy = 0;
    step(); step(); step();
    checks++; if (stallCycles !== 16'd3) begin failures++; $display("FAIL rst_prewait_cnt got=%0d exp=3", stallCycles); end
    rstN = 0; #1;
    checks++; if ({pcWe, ifIdFlush, memWbBubble} !== 3'b011) begin failures++; $display("FAIL rst_midwait got=%b exp=011", {pcWe, ifIdFlush, memWbBubble}); end
    checks++; if (stallCycles !== 16'd0 || memTimeout !== 1'b0) begin failures++; $display("FAIL rst_midwait_cnt got=%0d/%b exp=0/0", stallCycles, memTimeout); end
    clearIns(); #1; rstN = 1; #1;
    checks++; if ({pcWe, exMemWe, memWbBubble} !== 3'b110) begin failures++; $display("FAIL rst_after got=%b exp=110", {pcWe, exMemWe, memWbBubble}); end
    step();
    checks++; if (stallCycles !== 16'd0) begin failures++; $display("FAIL rst_no_residual got=%0d exp=0", stallCycles); end
  endtask

  task automatic test_load_use();
    doReset();
    weExec = 1; dstExec = 5'd3; selExec = 2'b01; rs1Addr = 5'd3; rs1Used = 1; #1;
    checks++; if ({pcWe, ifIdWe, idExFlush} !== 3'b001) begin failures++; $display("FAIL lu_ex got=%b exp=001", {pcWe, ifIdWe, idExFlush}); end
    step();
    weExec = 0; dstExec = '0; selExec = '0; weMem = 1; dstMem = 5'd3; selMem = 2'b01; #1;
    checks++; if ({pcWe, ifIdWe, idExFlush} !== 3'b001) begin failures++; $display("FAIL lu_mem got=%b exp=001", {pcWe, ifIdWe, idExFlush}); end
    step();
    weMem = 0; dstMem = '0; selMem = '0; #1;
    checks++; if ({pcWe, idExFlush} !== 2'b10) begin failures++; $display("FAIL lu_proceed got=%b exp=10", {pcWe, idExFlush}); end
    checks++; if (stallCycles !== 16'd2) begin failures++; $display("FAIL lu_cnt got=%0d exp=2", stallCycles); end
    // source not used: no stall
    weExec = 1; dstExec = 5'd3; selExec = 2'b01; rs1Used = 0; #1;
    checks++; if ({pcWe, idExFlush} !== 2'b10) begin failures++; $display("FAIL lu_unused got=%b exp=10", {pcWe, idExFlush}); end
    // non-load producer in EX: forwarded, no stall
    rs1Used = 1; selExec = 2'b00; #1;
    checks++; if (pcWe !== 1'b1) begin failures++; $display("FAIL lu_alu got=%b exp=1", pcWe); end
    // r0 is an ordinary register for hazard purposes
    rs1Used = 0; selExec = 2'b01; dstExec = 5'd0; rs2Addr = 5'd0; rs2Used = 1; #1;
    checks++; if ({pcWe, idExFlush} !== 2'b01) begin failures++; $display("FAIL lu_r0 got=%b exp=01", {pcWe, idExFlush}); end
    clearIns();
  endtask

  task automatic test_mem_wait();
    doReset();
    memAcc = 1; memRdy = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({pcWe, exMemWe, memWbBubble} !== 3'b001) begin failures++; $display("FAIL mw_freeze%0d got=%b exp=001", i, {pcWe, exMemWe, memWbBubble}); end
      step();
    end
    memRdy = 1; #1;
    checks++; if ({pcWe, exMemWe, memWbBubble} !== 3'b110) begin failures++; $display("FAIL mw_done got=%b exp=110", {pcWe, exMemWe, memWbBubble}); end
    checks++; if (stallCycles !== 16'd4) begin failures++; $display("FAIL mw_cnt got=%0d exp=4", stallCycles); end
    step();
    memAcc = 0; memRdy = 0; #1;
    checks++; if (pcWe !== 1'b1) begin failures++; $display("FAIL mw_back_run got=%b exp=1", pcWe); end
    // ready in the first cycle: no stall and no MEM_WAIT
    doReset();
    memAcc = 1; memRdy = 1; #1;
    checks++; if (pcWe !== 1'b1) begin failures++; $display("FAIL mw_fast got=%b exp=1", pcWe); end
    step();
    memAcc = 0; memRdy = 0; #1;
    checks++; if ({pcWe, memWbBubble} !== 2'b10) begin failures++; $display("FAIL mw_fast_nowait got=%b exp=10", {pcWe, memWbBubble}); end
    checks++; if (stallCycles !== 16'd0) begin failures++; $display("FAIL mw_fast_cnt got=%0d exp=0", stallCycles); end
  endtask

  task automatic test_branch_hazard();
    doReset();
    brTaken = 1; weMem = 1; dstMem = 5'd7; selMem = 2'b01; rs2Addr = 5'd7; rs2Used = 1; #1;
    checks++; if ({ifIdFlush, idExFlush, pcWe, ifIdWe} !== 4'b1111) begin failures++; $display("FAIL br_flush got=%b exp=1111", {ifIdFlush, idExFlush, pcWe, ifIdWe}); end
    step();
    clearIns(); #1;
    checks++; if ({pcWe, ifIdWe, exMemWe, ifIdFlush, idExFlush, memWbBubble} !== 6'b111000) begin failures++; $display("FAIL br_next got=%b exp=111000", {pcWe, ifIdWe, exMemWe, ifIdFlush, idExFlush, memWbBubble}); end
    checks++; if (stallCycles !== 16'd0) begin failures++; $display("FAIL br_cnt got=%0d exp=0", stallCycles); end
  endtask

  task automatic test_timeout();
    doReset();
    memAcc = 1; memRdy = 0;
    step(); step(); step(); // now in wait cycle 3 of dut2
    checks++; if (memTimeout2 !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", memTimeout2); end
    step();
    checks++; if (memTimeout2 !== 1'b1) begin failures++; $display("FAIL to_set got=%b exp=1", memTimeout2); end
    checks++; if ({pcWe2, ifIdWe2, exMemWe2, ifIdFlush2, idExFlush2, memWbBubble2} !== 6'b000111) begin failures++; $display("FAIL to_freeze got=%b exp=000111", {pcWe2, ifIdWe2, exMemWe2, ifIdFlush2, idExFlush2, memWbBubble2}); end
    memAcc = 0; memRdy = 1; step(); step();
    checks++; if ({memTimeout2, pcWe2} !== 2'b10) begin failures++; $display("FAIL to_sticky got=%b exp=10", {memTimeout2, pcWe2}); end
    doReset();
    checks++; if ({memTimeout2, pcWe2} !== 2'b01) begin failures++; $display("FAIL to_cleared got=%b exp=01", {memTimeout2, pcWe2}); end
    // ready on the last tolerated wait cycle still completes
    memAcc = 1; memRdy = 0;
    step(); step(); step();
    memRdy = 1; #1;
    checks++; if (pcWe2 !== 1'b1) begin failures++; $display("FAIL to_last_ok got=%b exp=1", pcWe2); end
    step();
    memAcc = 0; memRdy = 0; #1;
    checks++; if ({memTimeout2, pcWe2} !== 2'b01) begin failures++; $display("FAIL to_last_run got=%b exp=01", {memTimeout2, pcWe2}); end
  endtask

  task automatic test_counter();
    doReset();
    memAcc = 1; memRdy = 0;
    for (int i = 0; i < 20; i++) step();
    checks++; if (stallCycles2 !== 4'd15) begin failures++; $display("FAIL cnt_sat got=%0d exp=15", stallCycles2); end
    checks++; if (stallCycles !== 16'd20) begin failures++; $display("FAIL cnt_wide got=%0d exp=20", stallCycles); end
    cntClr = 1; step();
    checks++; if (stallCycles2 !== 4'd0 || stallCycles !== 16'd0) begin failures++; $display("FAIL cnt_clr got=%0d/%0d exp=0/0", stallCycles2, stallCycles); end
    cntClr = 0; step();
    checks++; if (stallCycles2 !== 4'd1) begin failures++; $display("FAIL cnt_resume got=%0d exp=1", stallCycles2); end
    doReset();
  endtask

  initial begin
    clearIns();
    rstN = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_hazard();
    test_timeout();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline interlock controller for the VeSPA 5-stage CPU; it complements the forwarding unit. Forwarding resolves ALU/LDI results from MEM and any result from WB, but load data is not forwardable from EX or MEM. This block therefore detects load-use hazards, freezes the pipeline while a multi-cycle data-memory access is outstanding, and flushes wrong-path instructions on a taken branch. It drives the write enables and flush controls of the PC and pipeline registers, and keeps a stall-cycle performance counter.

## Interface
- REG_ADDR_W, 5, register-file address width
- CNT_W, 16, stall counter width
- MEM_TIMEOUT, 15, max MEM_WAIT cycles before fatal timeout (≥1)

Ports:
- i_Clk  in  1  core clock, rising edge
- i_Rst_n  in  1  reset; one clock, asynchronous, active-low
- i_Rs1AddrDecode, i_Rs2AddrDecode  in  REG_ADDR_W  source addresses of the instruction in ID
- i_Rs1UsedDecode, i_Rs2UsedDecode  in  1  source actually read by the ID instruction
- i_RfWeExec  in  1  RF write enable, ID/EX register
- i_RfDstExec  in  REG_ADDR_W  RF destination, ID/EX register
- i_RfDataInSelExec  in  2  RF input select, ID/EX; 2'b01 = data-memory load
- i_RfWeMem, i_RfDstMem, i_RfDataInSelMem  in  1/REG_ADDR_W/2  same fields, EX/MEM register
- i_MemAccessMem  in  1  valid LD/ST in MEM stage
- i_MemReady  in  1  data memory completes the access this cycle
- i_BranchTakenExec  in  1  branch/jump in EX resolved taken
- i_CntClr  in  1  synchronous clear of o_StallCycles
- o_PcWe  out  1  PC write enable
- o_IfIdWe  out  1  IF/ID register write enable
- o_IfIdFlush  out  1  IF/ID loads NOP
- o_IdExFlush  out  1  ID/EX loads NOP (bubble)
- o_ExMemWe  out  1  EX/MEM register write enable
- o_MemWbBubble  out  1  MEM/WB loads NOP
- o_MemTimeout  out  1  sticky fatal memory timeout
- o_StallCycles  out  CNT_W  saturating count of cycles with o_PcWe=0

## Operation
- States: RUN, MEM_WAIT, ERR. The wait counter (4+ bits, sized for MEM_TIMEOUT) is cleared on every entry to MEM_WAIT.
- Outputs are combinational from state and current inputs. Defaults: o_PcWe=o_IfIdWe=o_ExMemWe=1, all flush/bubble signals 0.
- The load hazard is the OR of two matches, each requiring a used ID source equal to the destination:
  - EX match: i_RfWeExec && i_RfDataInSelExec==2'b01
  - MEM match: i_RfWeMem && i_RfDataInSelMem==2'b01
  - Address 0 is not special.
- Priority in RUN, highest first:
  1. Memory busy (i_MemAccessMem && !i_MemReady): o_PcWe=o_IfIdWe=o_ExMemWe=0, o_MemWbBubble=1. Next state MEM_WAIT.
  2. Branch taken: o_IfIdFlush=1, o_IdExFlush=1, o_PcWe=1 (target load).
  3. Load hazard: o_PcWe=0, o_IfIdWe=0, o_IdExFlush=1.
- A taken branch overrides a load hazard; the stalled ID instruction is wrong-path.
- MEM_WAIT:
  - !i_MemReady: freeze as in RUN rule 1, increment wait counter.
  - Counter reaching MEM_TIMEOUT with !i_MemReady: next state ERR.
  - i_MemReady=1: outputs evaluated with rules 2 and 3 as in RUN (the pipeline advances this cycle), next state RUN.
- ERR: full freeze (o_PcWe=o_IfIdWe=o_ExMemWe=0, o_IfIdFlush=o_IdExFlush=o_MemWbBubble=1), o_MemTimeout=1. Exit only by reset.
- o_StallCycles: +1 on each clock edge where o_PcWe=0. It saturates at all-ones. i_CntClr wins over increment (result 0).

## Timing
- Reset (i_Rst_n low, asynchronous): state RUN, wait counter 0, o_StallCycles=0, o_MemTimeout=0.
- While i_Rst_n is low: o_PcWe=o_IfIdWe=o_ExMemWe=0, o_IfIdFlush=o_IdExFlush=o_MemWbBubble=1.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN with no residual stall.
- Zero-latency control: hazard outputs are valid in the same cycle as the triggering inputs.
- Load-use back-to-back: the ID consumer stalls 2 cycles (load in EX, then load in MEM), then proceeds with WB forwarding.
- Branch flush lasts exactly 1 cycle per i_BranchTakenExec cycle.
- A memory access with ready in the first cycle causes no stall and no MEM_WAIT entry.
- MEM_WAIT with MEM_TIMEOUT=N: N cycles of !ready are tolerated. Ready on wait cycle N still completes; otherwise ERR is entered.

## Test plan
- Reset: drive i_Rst_n=0 mid-MEM_WAIT -> outputs immediately at reset values, o_StallCycles=0. After release, o_PcWe=1.
- Load-use: LD r3 in EX, ID reads r3 (rs1 used) -> o_PcWe=0, o_IdExFlush=1 for 2 cycles. Cycle 3 o_PcWe=1, o_StallCycles=2. Same case with i_Rs1UsedDecode=0 -> no stall.
- Memory wait: i_MemAccessMem=1, i_MemReady low 4 cycles -> o_ExMemWe=0 and o_MemWbBubble=1 for 4 cycles. Ready on cycle 5 -> RUN, o_StallCycles=4.
- Branch with concurrent hazard: i_BranchTakenExec=1 and MEM-stage load matching ID rs2 -> o_IfIdFlush=o_IdExFlush=1, o_PcWe=1 in the same cycle. Next cycle all defaults.
- Timeout: MEM_TIMEOUT=3, ready never asserts -> o_MemTimeout=1 after the 3rd wait cycle. Full freeze persists until reset, then clears.
- Counter: CNT_W=4, hold memory busy 20 cycles -> o_StallCycles saturates at 15. i_CntClr during a stall -> 0 on the next edge.
